// File: rtl/fprint_compare_scheduler_pkg.sv
// Shared types and constants for the fingerprint comparison scheduler.
// Also holds the majority-vote helper used when FPRINT_SCHED_TMR_VOTE_EN is defined.
package fprint_compare_scheduler_pkg;

  // Defaults shared with the CRC fingerprint register block
  localparam int FPRINT_KEY_SIZE   = 16;
  localparam int FPRINT_ADDR_WIDTH = 5;

  localparam logic [1:0] FAULTY_CORE_UNKNOWN = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECT,
    ST_LOAD,
    ST_READ,
    ST_COMPARE,
    ST_RESULT,
    ST_RESET_REQ
  } sched_state_e;

  // Names the odd core out of three pairwise equality flags
  function automatic logic [1:0] vote_core(input logic eq01, input logic eq02, input logic eq12);
    if (eq12 && !eq01)      return 2'd0;
    else if (eq02 && !eq01) return 2'd1;
    else if (eq01 && !eq02) return 2'd2;
    else                    return FAULTY_CORE_UNKNOWN;
  endfunction

endpackage

// File: rtl/fprint_compare_scheduler_rr_arbiter.sv
// Combinational round-robin grant over KEY_SIZE requests.
// The search starts one slot after last_grant and wraps at KEY_SIZE.
module fprint_rr_arbiter #(
  parameter int KEY_SIZE  = 16,
  parameter int KEY_WIDTH = 4
) (
  input  logic [KEY_SIZE-1:0]  req,
  input  logic [KEY_WIDTH-1:0] last_grant,
  output logic [KEY_WIDTH-1:0] grant,
  output logic                 valid
);

  logic [KEY_WIDTH:0] idx;

  always_comb begin
    grant = '0;
    valid = 1'b0;
    idx   = '0;
    for (int i = 1; i <= KEY_SIZE; i++) begin
      idx = {1'b0, last_grant} + (KEY_WIDTH+1)'(i);
      if (idx >= (KEY_WIDTH+1)'(KEY_SIZE)) idx = idx - (KEY_WIDTH+1)'(KEY_SIZE);
      if (!valid && req[idx[KEY_WIDTH-1:0]]) begin
        valid = 1'b1;
        grant = idx[KEY_WIDTH-1:0];
      end
    end
  end

endmodule

// File: rtl/fprint_compare_scheduler.sv
// Sequences fingerprint comparison: round-robin task pick, DMR/TMR buffer walk, verdict, reset handshake.
// Define FPRINT_SCHED_TMR_VOTE_EN to identify the faulty core of TMR tasks by majority vote.
module fprint_compare_scheduler
  import fprint_compare_scheduler_pkg::*;
#(
  parameter int KEY_SIZE   = FPRINT_KEY_SIZE,
  parameter int KEY_WIDTH  = 4,
  parameter int ADDR_WIDTH = FPRINT_ADDR_WIDTH,
  parameter int CRC_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [KEY_SIZE-1:0]   fprint_checkin,
  input  logic [KEY_SIZE-1:0]   fprint_nmr,
  input  logic [ADDR_WIDTH-1:0] task_base_pointer_0,
  input  logic [ADDR_WIDTH-1:0] task_base_pointer_1,
  input  logic [ADDR_WIDTH-1:0] task_base_pointer_2,
  input  logic [ADDR_WIDTH-1:0] task_head_pointer_0,
  input  logic [ADDR_WIDTH-1:0] task_head_pointer_1,
  input  logic [ADDR_WIDTH-1:0] task_head_pointer_2,
  input  logic [CRC_WIDTH-1:0]  fprint_0,
  input  logic [CRC_WIDTH-1:0]  fprint_1,
  input  logic [CRC_WIDTH-1:0]  fprint_2,
  output logic [ADDR_WIDTH-1:0] comp_tail_pointer_0,
  output logic [ADDR_WIDTH-1:0] comp_tail_pointer_1,
  output logic [ADDR_WIDTH-1:0] comp_tail_pointer_2,
  output logic [KEY_WIDTH-1:0]  comparator_task_id,
  output logic                  fprint_reset_task,
  input  logic                  fprint_reset_task_ack,
  output logic                  result_valid,
  output logic [KEY_WIDTH-1:0]  result_task_id,
  output logic                  result_fault,
  output logic [1:0]            result_faulty_core,
  output logic                  busy
);

  sched_state_e          state_q, state_d;
  logic [KEY_WIDTH-1:0]  last_grant_q, task_id_q;
  logic                  nmr_q;
  logic [ADDR_WIDTH-1:0] tail0_q, tail1_q, tail2_q;
  logic                  fault_q;
  logic [1:0]            core_q;

  logic [KEY_WIDTH-1:0]  grant;
  logic                  grant_valid;
  logic [ADDR_WIDTH-1:0] len0, len1, len2;
  logic                  len_ok, eq01, eq02, match, last_entry;
  logic [1:0]            cmp_core, len_core;

  logic                  take_grant, load_tails, inc_tails, set_verdict, verdict_fault;
  logic [1:0]            verdict_core;

  fprint_rr_arbiter #(
    .KEY_SIZE  (KEY_SIZE),
    .KEY_WIDTH (KEY_WIDTH)
  ) u_arbiter (
    .req        (fprint_checkin),
    .last_grant (last_grant_q),
    .grant      (grant),
    .valid      (grant_valid)
  );

  // Core 2 only takes part in TMR tasks
  assign len0       = task_head_pointer_0 - task_base_pointer_0;
  assign len1       = task_head_pointer_1 - task_base_pointer_1;
  assign len2       = task_head_pointer_2 - task_base_pointer_2;
  assign len_ok     = (len0 == len1) && (!nmr_q || (len0 == len2));
  assign eq01       = (fprint_0 == fprint_1);
  assign eq02       = (fprint_0 == fprint_2);
  assign match      = eq01 && (!nmr_q || eq02);
  assign last_entry = ((tail0_q + ADDR_WIDTH'(1)) == task_head_pointer_0);

`ifdef FPRINT_SCHED_TMR_VOTE_EN
  logic eq12;
  assign eq12     = (fprint_1 == fprint_2);
  assign cmp_core = nmr_q ? vote_core(eq01, eq02, eq12) : FAULTY_CORE_UNKNOWN;
  assign len_core = nmr_q ? vote_core(len0 == len1, len0 == len2, len1 == len2) : FAULTY_CORE_UNKNOWN;
`else
  assign cmp_core = FAULTY_CORE_UNKNOWN;
  assign len_core = FAULTY_CORE_UNKNOWN;
`endif

  always_comb begin
    state_d       = state_q;
    take_grant    = 1'b0;
    load_tails    = 1'b0;
    inc_tails     = 1'b0;
    set_verdict   = 1'b0;
    verdict_fault = 1'b0;
    verdict_core  = 2'd0;
    case (state_q)
      ST_IDLE: begin
        if (|fprint_checkin) state_d = ST_SELECT;
      end
      ST_SELECT: begin
        if (grant_valid) begin
          take_grant = 1'b1;
          state_d    = ST_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        load_tails = 1'b1;
        if (!len_ok) begin
          set_verdict   = 1'b1;
          verdict_fault = 1'b1;
          verdict_core  = len_core;
          state_d       = ST_RESULT;
        end else if (len0 == '0) begin
          set_verdict = 1'b1;
          state_d     = ST_RESULT;
        end else begin
          state_d = ST_READ;
        end
      end
      ST_READ: begin
        state_d = ST_COMPARE;
      end
      ST_COMPARE: begin
        if (!match) begin
          set_verdict   = 1'b1;
          verdict_fault = 1'b1;
          verdict_core  = cmp_core;
          state_d       = ST_RESULT;
        end else if (last_entry) begin
          set_verdict = 1'b1;
          state_d     = ST_RESULT;
        end else begin
          inc_tails = 1'b1;
          state_d   = ST_READ;
        end
      end
      ST_RESULT: begin
        state_d = ST_RESET_REQ;
      end
      ST_RESET_REQ: begin
        if (fprint_reset_task_ack) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Task id stays latched from SELECT through the whole reset handshake
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      last_grant_q <= KEY_WIDTH'(KEY_SIZE - 1);
      task_id_q    <= '0;
      nmr_q        <= 1'b0;
      tail0_q      <= '0;
      tail1_q      <= '0;
      tail2_q      <= '0;
      fault_q      <= 1'b0;
      core_q       <= 2'd0;
    end else begin
      state_q <= state_d;
      if (take_grant) begin
        task_id_q    <= grant;
        last_grant_q <= grant;
        nmr_q        <= fprint_nmr[grant];
      end
      if (load_tails) begin
        tail0_q <= task_base_pointer_0;
        tail1_q <= task_base_pointer_1;
        if (nmr_q) tail2_q <= task_base_pointer_2;
      end
      if (inc_tails) begin
        tail0_q <= tail0_q + ADDR_WIDTH'(1);
        tail1_q <= tail1_q + ADDR_WIDTH'(1);
        if (nmr_q) tail2_q <= tail2_q + ADDR_WIDTH'(1);
      end
      if (set_verdict) begin
        fault_q <= verdict_fault;
        core_q  <= verdict_core;
      end
    end
  end

  assign comp_tail_pointer_0 = tail0_q;
  assign comp_tail_pointer_1 = tail1_q;
  assign comp_tail_pointer_2 = tail2_q;
  assign comparator_task_id  = task_id_q;
  assign busy                = (state_q != ST_IDLE);
  assign fprint_reset_task   = (state_q == ST_RESET_REQ);
  assign result_valid        = (state_q == ST_RESULT);
  assign result_task_id      = result_valid ? task_id_q : '0;
  assign result_fault        = result_valid & fault_q;
  assign result_faulty_core  = result_valid ? core_q : 2'd0;

endmodule
